reg_add: RTL

Adder hold register (ADD) for the 6502 datapath: the output end of the ALU, complementing the AI/BI input registers. It latches the ALU result and carry/overflow flags, optionally applies a one-cycle BCD decimal correction, then holds the result and drives it onto the SB bus (split bits 0–6 / bit 7) and the ADL bus under control-unit enables.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/decimal_adjust.sv | 57 +++++
 rtl/reg_add.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the 6502 datapath blocks.
//
// Contents:
//   add_state_t   - state of the ADD hold register (IDLE, ADJUST, HOLD)
//   BCD_LO_ADJ    - low-digit decimal correction term (8'h06)
//   BCD_HI_ADJ    - high-digit decimal correction term (8'h60)
//   BCD_MAX       - largest valid packed-BCD byte (8'h99)
//   sb_drive_mask - expands the split SB enables into a per-bit mask
// ---------------------------------------------------------------------------
package cpu_pkg;

  // IDLE   : nothing has been captured since reset
  // ADJUST : raw ALU value captured, BCD correction lands on the next edge
  // HOLD   : hold register contains a completed result
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    HOLD   = 2'd2
  } add_state_t;

  localparam logic [7:0] BCD_LO_ADJ = 8'h06;
  localparam logic [7:0] BCD_HI_ADJ = 8'h60;
  localparam logic [7:0] BCD_MAX    = 8'h99;

  // SB is split: one enable covers bits 6:0, another covers bit 7.
  function automatic logic [7:0] sb_drive_mask(input logic high_en,
                                               input logic low_en);
    return {high_en, {7{low_en}}};
  endfunction

endpackage : cpu_pkg

// File: rtl/decimal_adjust.sv
// ---------------------------------------------------------------------------
// decimal_adjust
// Combinational packed-BCD correction of a raw binary ALU result.
// Only present when DECIMAL_MODE_EN is defined.
//
// Ports:
//   raw        in  8  raw binary ALU result
//   carry      in  1  raw ALU carry (for subtract: 1 = no borrow)
//   half_carry in  1  raw carry out of bit 3 (for subtract: 1 = no borrow)
//   sub        in  1  0 = correct an addition, 1 = correct a subtraction
//   result     out 8  corrected BCD value
//   carry_out  out 1  corrected decimal carry
// ---------------------------------------------------------------------------
`ifdef DECIMAL_MODE_EN
module decimal_adjust
  import cpu_pkg::*;
(
  input  logic [7:0] raw,
  input  logic       carry,
  input  logic       half_carry,
  input  logic       sub,
  output logic [7:0] result,
  output logic       carry_out
);

  logic       lo_fix;
  logic       hi_fix;
  logic [7:0] add_result;
  logic [7:0] sub_result;

  // Addition: a digit needs +6 when it overflowed (carry out of it) or
  // landed on a non-decimal code. The high test looks at the whole byte so
  // a low-digit fix that ripples into the high digit is accounted for.
  assign lo_fix = half_carry | (raw[3:0] > 4'd9);
  assign hi_fix = carry | (raw > BCD_MAX);

  assign add_result = raw
                    + (lo_fix ? BCD_LO_ADJ : 8'h00)
                    + (hi_fix ? BCD_HI_ADJ : 8'h00);

  // Subtraction: a digit that borrowed (its carry flag is 0) wrapped past
  // 0 in binary, so 6 is taken back off it. Both sums wrap mod 256.
  assign sub_result = raw
                    - (half_carry ? 8'h00 : BCD_LO_ADJ)
                    - (carry      ? 8'h00 : BCD_HI_ADJ);

  always_comb begin
    result    = add_result;
    carry_out = hi_fix;
    if (sub) begin
      result    = sub_result;
      carry_out = carry;
    end
  end

endmodule : decimal_adjust
`endif

// File: rtl/reg_add.sv
// ---------------------------------------------------------------------------
// reg_add
// ADD hold register at the output of the 6502 ALU. Captures the ALU result
// and carry/overflow flags, optionally applies a one-cycle BCD correction,
// then holds the result and drives it onto SB (bits 6:0 / bit 7 split) and
// ADL under control-unit enables.
//
// Configuration macro:
//   DECIMAL_MODE_EN  defined   : DECIMAL=1 loads take a correction cycle
//                               in ADJUST (2-cycle latency, BUSY for 1)
//                    undefined : DECIMAL and SUB ignored, every load is
//                               binary, BUSY tied 0, ADJUST never entered
//
// Ports:
//   CLK            in  1  clock, rising edge
//   RST_N          in  1  asynchronous active-low reset
//   FROM_ALU       in  8  raw ALU result
//   ALU_CARRY      in  1  ALU carry out
//   ALU_OVF        in  1  ALU signed overflow
//   ALU_HALF_CARRY in  1  carry out of bit 3
//   ADD_LOAD       in  1  capture request (ignored while in ADJUST)
//   DECIMAL        in  1  apply BCD correction to this capture
//   SUB            in  1  correction mode: 0 add, 1 subtract
//   SB_LOW_EN      in  1  drive bits 6:0 onto SB
//   SB_HIGH_EN     in  1  drive bit 7 onto SB
//   ADL_EN         in  1  drive all 8 bits onto ADL
//   SB_DATA        out 8  held value masked by SB_DRIVE
//   SB_DRIVE       out 8  per-bit SB drive mask
//   ADL_DATA       out 8  held value when ADL_DRIVE, else 0
//   ADL_DRIVE      out 1  ADL drive active
//   ACR            out 1  held carry (after correction)
//   AVR            out 1  held overflow (raw ALU value)
//   VALID          out 1  state is HOLD
//   BUSY           out 1  state is ADJUST
//
// Handshake: ADD_LOAD is a single-cycle request sampled on each rising edge
// while in IDLE or HOLD; it has no ready. VALID is the completion
// indication and stays high until reset or a decimal load moves to ADJUST.
// ---------------------------------------------------------------------------
module reg_add
  import cpu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] FROM_ALU,
  input  logic       ALU_CARRY,
  input  logic       ALU_OVF,
  input  logic       ALU_HALF_CARRY,
  input  logic       ADD_LOAD,
  input  logic       DECIMAL,
  input  logic       SUB,
  input  logic       SB_LOW_EN,
  input  logic       SB_HIGH_EN,
  input  logic       ADL_EN,
  output logic [7:0] SB_DATA,
  output logic [7:0] SB_DRIVE,
  output logic [7:0] ADL_DATA,
  output logic       ADL_DRIVE,
  output logic       ACR,
  output logic       AVR,
  output logic       VALID,
  output logic       BUSY
);

  add_state_t state;
  logic [7:0] hold_reg;
  logic       acr_q;
  logic       avr_q;
  logic       in_hold;

`ifdef DECIMAL_MODE_EN
  // During ADJUST, hold_reg/acr_q carry the raw ALU value and carry; the
  // half carry and mode are kept alongside so the corrector sees a stable
  // operand set regardless of what the ALU is doing that cycle.
  logic       hc_q;
  logic       sub_q;
  logic [7:0] adj_result;
  logic       adj_carry;

  decimal_adjust u_decimal_adjust (
    .raw        (hold_reg),
    .carry      (acr_q),
    .half_carry (hc_q),
    .sub        (sub_q),
    .result     (adj_result),
    .carry_out  (adj_carry)
  );
`else
  // Decimal controls have no effect in a binary-only build.
  logic unused_decimal_inputs;
  assign unused_decimal_inputs = &{1'b0, DECIMAL, SUB, ALU_HALF_CARRY};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      hold_reg <= 8'h00;
      acr_q    <= 1'b0;
      avr_q    <= 1'b0;
`ifdef DECIMAL_MODE_EN
      hc_q     <= 1'b0;
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (ADD_LOAD) begin
            hold_reg <= FROM_ALU;
            acr_q    <= ALU_CARRY;
            avr_q    <= ALU_OVF;
`ifdef DECIMAL_MODE_EN
            if (DECIMAL) begin
              hc_q  <= ALU_HALF_CARRY;
              sub_q <= SUB;
              state <= ADJUST;
            end else begin
              state <= HOLD;
            end
`else
            state <= HOLD;
`endif
          end
        end
`ifdef DECIMAL_MODE_EN
        // Correction lands here; any ADD_LOAD this cycle is dropped, not
        // queued. AVR keeps the raw overflow captured on entry.
        ADJUST: begin
          hold_reg <= adj_result;
          acr_q    <= adj_carry;
          state    <= HOLD;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Drives follow the current held value; only a completed result is ever
  // put on a bus, so enables in IDLE/ADJUST are masked off.
  assign in_hold   = (state == HOLD);
  assign SB_DRIVE  = in_hold ? sb_drive_mask(SB_HIGH_EN, SB_LOW_EN) : 8'h00;
  assign SB_DATA   = hold_reg & SB_DRIVE;
  assign ADL_DRIVE = in_hold & ADL_EN;
  assign ADL_DATA  = ADL_DRIVE ? hold_reg : 8'h00;

  assign ACR   = acr_q;
  assign AVR   = avr_q;
  assign VALID = in_hold;
  assign BUSY  = (state == ADJUST);

endmodule : reg_add
